// File: rtl/regbank_write_arbiter_if.sv
// Bus bundle between the write requesters / reader and the register-bank arbiter.
// Master drives requests, soft-clear and read address; slave returns grants, busy and read data.
interface regbank_write_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
);
    logic [3:0]         req;
    logic [4*AW-1:0]    wr_addr;
    logic [4*WIDTH-1:0] wr_data;
    logic               soft_clr;
    logic [3:0]         gnt;
    logic               clr_busy;
    logic [AW-1:0]      rd_addr;
    logic [WIDTH-1:0]   rd_data;

    modport master (
        output req, wr_addr, wr_data, soft_clr, rd_addr,
        input  gnt, clr_busy, rd_data
    );

    modport slave (
        input  req, wr_addr, wr_data, soft_clr, rd_addr,
        output gnt, clr_busy, rd_data
    );
endinterface

// File: rtl/regbank_write_arbiter.sv
// Round-robin arbiter sharing one register-bank write port among 4 requesters,
// with a sequenced soft-clear that zeroes one entry per cycle.
module regbank_write_arbiter #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input logic                   clock,
    input logic                   clearb,
    regbank_write_arbiter_if.slave bus
);
    localparam int DEPTH = 2**AW;

    typedef enum logic {ARB, CLEAR} state_t;

    state_t           state;
    logic [1:0]       ptr;
    logic [AW-1:0]    cnt;
    logic [3:0]       gnt_r;
    logic             busy_r;
    logic [WIDTH-1:0] bank [DEPTH];

    logic [3:0]       eligible;
    logic             win_vld;
    logic [1:0]       win_idx;
    logic [1:0]       scan_idx;
    logic [AW-1:0]    sel_addr;
    logic [WIDTH-1:0] sel_data;

    // Scan from ptr downward in priority so the lowest offset from ptr is the last (winning) assignment.
    always_comb begin
        eligible = bus.req & ~gnt_r;
        win_vld  = 1'b0;
        win_idx  = ptr;
        scan_idx = ptr;
        for (int k = 3; k >= 0; k--) begin
            scan_idx = ptr + 2'(k);
            if (eligible[scan_idx]) begin
                win_vld = 1'b1;
                win_idx = scan_idx;
            end
        end
        sel_addr = '0;
        sel_data = '0;
        for (int j = 0; j < 4; j++) begin
            if (win_idx == 2'(j)) begin
                sel_addr = bus.wr_addr[j*AW +: AW];
                sel_data = bus.wr_data[j*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clock or negedge clearb) begin
        if (!clearb) begin
            state  <= ARB;
            ptr    <= 2'd0;
            cnt    <= '0;
            gnt_r  <= 4'b0000;
            busy_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (bus.soft_clr) begin
                        state  <= CLEAR;
                        cnt    <= '0;
                        gnt_r  <= 4'b0000;
                        busy_r <= 1'b1;
                    end else if (win_vld) begin
                        bank[sel_addr] <= sel_data;
                        gnt_r          <= 4'b0001 << win_idx;
                        ptr            <= win_idx + 2'd1;
                    end else begin
                        gnt_r <= 4'b0000;
                    end
                end
                CLEAR: begin
                    // Requests are left pending; ptr is untouched so fairness resumes where it left off.
                    bank[cnt] <= '0;
                    gnt_r     <= 4'b0000;
                    cnt       <= cnt + AW'(1);
                    if (cnt == AW'(DEPTH - 1)) begin
                        state  <= ARB;
                        busy_r <= 1'b0;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    assign bus.gnt      = gnt_r;
    assign bus.clr_busy = busy_r;
    assign bus.rd_data  = bank[bus.rd_addr];
endmodule
